// File: rtl/crc_stream_engine.sv
// rtl/crc_stream_engine.sv - streaming CRC generator/checker over framed words
`timescale 1ns/1ps
module crc_stream_engine #(
    parameter int               CRC_W    = 8,
    parameter int               DATA_W   = 8,
    parameter logic [CRC_W-1:0] POLY     = 8'hD5,
    parameter logic [CRC_W-1:0] INIT_VAL = '0,
    parameter logic [CRC_W-1:0] XOR_OUT  = '0,
    parameter logic [CRC_W-1:0] RESIDUE  = '0
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              INIT,
    input  logic              MODE,
    input  logic              IN_VALID,
    input  logic              IN_SOF,
    input  logic              IN_EOF,
    input  logic [DATA_W-1:0] IN_DATA,
    output logic              IN_READY,
    output logic              OUT_VALID,
    output logic              OUT_SOF,
    output logic              OUT_LAST,
    output logic [DATA_W-1:0] OUT_DATA,
    output logic [CRC_W-1:0]  CRC,
    output logic              CRC_VALID,
    output logic              CRC_OK,
    output logic              ERR_SOF
);

    localparam int N     = CRC_W / DATA_W;
    localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FRAME  = 2'd1,
        APPEND = 2'd2
    } state_t;

    state_t           state;
    logic [CRC_W-1:0] crc_reg;
    logic [CRC_W-1:0] app_sh;
    logic [CNT_W-1:0] cnt;
    logic             mode_r;

    logic             accept;
    logic             end_mode;
    logic [CRC_W-1:0] base_crc;
    logic [CRC_W-1:0] next_crc;

    // DATA_W serial LFSR steps unrolled into one combinational update, MSB first
    function automatic logic [CRC_W-1:0] crc_step(input logic [CRC_W-1:0] c_in,
                                                  input logic [DATA_W-1:0] d);
        logic [CRC_W-1:0] c;
        logic             fb;
        c = c_in;
        for (int i = DATA_W - 1; i >= 0; i--) begin
            fb = c[CRC_W-1] ^ d[i];
            c  = {c[CRC_W-2:0], 1'b0} ^ (fb ? POLY : '0);
        end
        return c;
    endfunction

    always_comb begin
        accept   = IN_VALID && IN_READY;
        base_crc = IN_SOF ? INIT_VAL : crc_reg;
        next_crc = crc_step(base_crc, IN_DATA);
        end_mode = IN_SOF ? MODE : mode_r;
    end

    always_ff @(posedge CLK) begin
        if (!RST || INIT) begin
            state     <= IDLE;
            crc_reg   <= INIT_VAL;
            app_sh    <= '0;
            cnt       <= '0;
            mode_r    <= 1'b0;
            IN_READY  <= 1'b1;
            OUT_VALID <= 1'b0;
            OUT_SOF   <= 1'b0;
            OUT_LAST  <= 1'b0;
            OUT_DATA  <= '0;
            CRC       <= '0;
            CRC_VALID <= 1'b0;
            CRC_OK    <= 1'b0;
            ERR_SOF   <= 1'b0;
        end else begin
            OUT_VALID <= 1'b0;
            OUT_SOF   <= 1'b0;
            OUT_LAST  <= 1'b0;
            CRC_VALID <= 1'b0;
            ERR_SOF   <= 1'b0;
            case (state)
                IDLE, FRAME: begin
                    if (accept) begin
                        if (!IN_SOF && state == IDLE) begin
                            ERR_SOF <= 1'b1;
                        end else begin
                            // a SOF here also abandons any frame in progress
                            crc_reg   <= next_crc;
                            OUT_VALID <= 1'b1;
                            OUT_DATA  <= IN_DATA;
                            OUT_SOF   <= IN_SOF;
                            if (IN_SOF) begin
                                mode_r <= MODE;
                            end
                            if (IN_EOF) begin
                                CRC       <= next_crc ^ XOR_OUT;
                                CRC_VALID <= 1'b1;
                                if (end_mode) begin
                                    CRC_OK   <= (next_crc == RESIDUE);
                                    OUT_LAST <= 1'b1;
                                    state    <= IDLE;
                                end else begin
                                    CRC_OK   <= 1'b0;
                                    app_sh   <= next_crc ^ XOR_OUT;
                                    cnt      <= '0;
                                    IN_READY <= 1'b0;
                                    state    <= APPEND;
                                end
                            end else begin
                                state <= FRAME;
                            end
                        end
                    end
                end
                APPEND: begin
                    OUT_VALID <= 1'b1;
                    OUT_DATA  <= app_sh[CRC_W-1 -: DATA_W];
                    app_sh    <= app_sh << DATA_W;
                    cnt       <= cnt + 1'b1;
                    if (cnt == LAST_CNT) begin
                        OUT_LAST <= 1'b1;
                        IN_READY <= 1'b1;
                        state    <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_crc_stream_engine.sv
// tb/tb_crc_stream_engine.sv - scoreboard bench for CRC-8/DVB-S2 and CRC-32/MPEG-2 instances
`timescale 1ns/1ps
module tb_crc_stream_engine;

    logic CLK = 1'b0;
    always #5 CLK = ~CLK;

    logic       RST;
    logic       init0, mode0, v0, sof0, eof0;
    logic [7:0] d0;
    logic       init1, mode1, v1, sof1, eof1;
    logic [7:0] d1;

    logic        rdy0, ov0, osof0, olast0, cv0, ok0, err0;
    logic [7:0]  od0, crc0;
    logic        rdy1, ov1, osof1, olast1, cv1, ok1, err1;
    logic [7:0]  od1;
    logic [31:0] crc1;

    crc_stream_engine u_dut0 (
        .CLK(CLK), .RST(RST), .INIT(init0), .MODE(mode0),
        .IN_VALID(v0), .IN_SOF(sof0), .IN_EOF(eof0), .IN_DATA(d0),
        .IN_READY(rdy0), .OUT_VALID(ov0), .OUT_SOF(osof0), .OUT_LAST(olast0),
        .OUT_DATA(od0), .CRC(crc0), .CRC_VALID(cv0), .CRC_OK(ok0), .ERR_SOF(err0)
    );

    crc_stream_engine #(
        .CRC_W(32), .DATA_W(8), .POLY(32'h04C11DB7), .INIT_VAL(32'hFFFFFFFF),
        .XOR_OUT(32'h0), .RESIDUE(32'h0)
    ) u_dut1 (
        .CLK(CLK), .RST(RST), .INIT(init1), .MODE(mode1),
        .IN_VALID(v1), .IN_SOF(sof1), .IN_EOF(eof1), .IN_DATA(d1),
        .IN_READY(rdy1), .OUT_VALID(ov1), .OUT_SOF(osof1), .OUT_LAST(olast1),
        .OUT_DATA(od1), .CRC(crc1), .CRC_VALID(cv1), .CRC_OK(ok1), .ERR_SOF(err1)
    );

    typedef struct packed {
        logic [7:0] data;
        logic       sof;
        logic       last;
    } out_t;

    typedef struct packed {
        logic [31:0] crc;
        logic        ok;
    } crc_t;

    out_t eo0[$], eo1[$];
    crc_t ec0[$], ec1[$];
    out_t e0, e1;
    crc_t c0, c1;

    int pass_cnt = 0;
    int total_cnt = 0;
    int err_seen[2];
    int err_exp[2];
    int rl_cnt[2];
    int cv_cnt[2];
    logic [31:0] last_crc[2];
    logic        last_ok[2];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h, required %h", name, act, exp);
    endtask

    // Reference: textbook MSB-first CRC, byte XORed into the top of the register
    function automatic logic [31:0] ref_raw(input int id, input logic [7:0] m[$]);
        int          w;
        logic [31:0] poly, r, mask;
        w    = (id == 0) ? 8 : 32;
        poly = (id == 0) ? 32'hD5 : 32'h04C11DB7;
        r    = (id == 0) ? 32'h0 : 32'hFFFFFFFF;
        mask = (id == 0) ? 32'hFF : 32'hFFFFFFFF;
        foreach (m[k]) begin
            r = r ^ ({24'h0, m[k]} << (w - 8));
            for (int b = 0; b < 8; b++) begin
                if (r[w-1]) r = ((r << 1) ^ poly) & mask;
                else        r = (r << 1) & mask;
            end
        end
        return r;
    endfunction

    always @(negedge CLK) begin
        if (RST === 1'b1 && rdy0 === 1'b0) rl_cnt[0]++;
        if (err0 === 1'b1) err_seen[0]++;
        if (ov0 === 1'b1) begin
            if (eo0.size() == 0) begin
                total_cnt++;
                $display("FAIL out0_extra: got word %h, required no output", od0);
            end else begin
                e0 = eo0.pop_front();
                check("out0_data", {24'h0, od0}, {24'h0, e0.data});
                check("out0_sof", {31'h0, osof0}, {31'h0, e0.sof});
                check("out0_last", {31'h0, olast0}, {31'h0, e0.last});
            end
        end
        if (cv0 === 1'b1) begin
            cv_cnt[0]++;
            last_crc[0] = {24'h0, crc0};
            last_ok[0]  = ok0;
            if (ec0.size() == 0) begin
                total_cnt++;
                $display("FAIL crc0_extra: got crc %h, required no CRC_VALID", crc0);
            end else begin
                c0 = ec0.pop_front();
                check("crc0_value", {24'h0, crc0}, c0.crc);
                check("crc0_ok", {31'h0, ok0}, {31'h0, c0.ok});
            end
        end
    end

    always @(negedge CLK) begin
        if (RST === 1'b1 && rdy1 === 1'b0) rl_cnt[1]++;
        if (err1 === 1'b1) err_seen[1]++;
        if (ov1 === 1'b1) begin
            if (eo1.size() == 0) begin
                total_cnt++;
                $display("FAIL out1_extra: got word %h, required no output", od1);
            end else begin
                e1 = eo1.pop_front();
                check("out1_data", {24'h0, od1}, {24'h0, e1.data});
                check("out1_sof", {31'h0, osof1}, {31'h0, e1.sof});
                check("out1_last", {31'h0, olast1}, {31'h0, e1.last});
            end
        end
        if (cv1 === 1'b1) begin
            cv_cnt[1]++;
            last_crc[1] = crc1;
            last_ok[1]  = ok1;
            if (ec1.size() == 0) begin
                total_cnt++;
                $display("FAIL crc1_extra: got crc %h, required no CRC_VALID", crc1);
            end else begin
                c1 = ec1.pop_front();
                check("crc1_value", crc1, c1.crc);
                check("crc1_ok", {31'h0, ok1}, {31'h0, c1.ok});
            end
        end
    end

    task automatic push_out(input int id, input logic [7:0] d, input logic s, input logic l);
        out_t o;
        o.data = d; o.sof = s; o.last = l;
        if (id == 0) eo0.push_back(o);
        else         eo1.push_back(o);
    endtask

    task automatic push_crc(input int id, input logic [31:0] c, input logic ok);
        crc_t x;
        x.crc = c; x.ok = ok;
        if (id == 0) ec0.push_back(x);
        else         ec1.push_back(x);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic send(input int id, input logic s, input logic e, input logic [7:0] d,
                        input logic md);
        int t;
        t = 0;
        if (id == 0) begin v0 = 1'b1; sof0 = s; eof0 = e; d0 = d; mode0 = md; end
        else         begin v1 = 1'b1; sof1 = s; eof1 = e; d1 = d; mode1 = md; end
        forever begin
            @(negedge CLK);
            if (((id == 0) ? rdy0 : rdy1) === 1'b1) break;
            t++;
            if (t > 50) begin
                total_cnt++;
                $display("FAIL send_timeout: got IN_READY low for %0d cycles, required high", t);
                break;
            end
        end
        @(posedge CLK);
        #1;
        if (id == 0) begin v0 = 1'b0; sof0 = 1'b0; eof0 = 1'b0; end
        else         begin v1 = 1'b0; sof1 = 1'b0; eof1 = 1'b0; end
    endtask

    // keep = number of appended CRC words expected to survive (for reset-mid-append)
    task automatic run_frame(input int id, input logic md, input logic [7:0] q[$], input int keep);
        logic [31:0] raw;
        int          nw, last;
        nw   = (id == 0) ? 1 : 4;
        last = q.size() - 1;
        raw  = ref_raw(id, q);
        for (int k = 0; k <= last; k++) begin
            push_out(id, q[k], k == 0, md && (k == last));
            if (k == last) begin
                push_crc(id, raw, md ? (raw == 32'h0) : 1'b0);
                if (!md) begin
                    for (int j = 0; j < nw && j < keep; j++)
                        push_out(id, raw[8*(nw-1-j) +: 8], 1'b0, j == nw - 1);
                end
            end
            send(id, k == 0, k == last, q[k], md);
        end
    endtask

    task automatic run_partial(input int id, input logic [7:0] q[$]);
        for (int k = 0; k < q.size(); k++) begin
            push_out(id, q[k], k == 0, 1'b0);
            send(id, k == 0, 1'b0, q[k], 1'b0);
        end
    endtask

    task automatic check_reset(input int id);
        if (id == 0) begin
            check("rst0_ready", {31'h0, rdy0}, 32'h1);
            check("rst0_outs", {25'h0, ov0, osof0, olast0, cv0, ok0, err0, 1'b0}, 32'h0);
            check("rst0_data", {16'h0, od0, crc0}, 32'h0);
        end else begin
            check("rst1_ready", {31'h0, rdy1}, 32'h1);
            check("rst1_outs", {25'h0, ov1, osof1, olast1, cv1, ok1, err1, 1'b0}, 32'h0);
            check("rst1_data", {24'h0, od1}, 32'h0);
            check("rst1_crc", crc1, 32'h0);
        end
    endtask

    initial begin
        #3000000;
        $display("FAIL watchdog: got no finish, required finish within time limit");
        $fatal(1);
    end

    initial begin
        logic [7:0] msg[$];
        logic [7:0] q[$];
        logic [31:0] raw;
        int          id, len, cvb;
        logic        md;

        msg = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
        for (int i = 0; i < 2; i++) begin
            err_seen[i] = 0; err_exp[i] = 0; rl_cnt[i] = 0; cv_cnt[i] = 0;
            last_crc[i] = '0; last_ok[i] = 1'b0;
        end
        RST = 1'b0;
        init0 = 0; mode0 = 0; v0 = 0; sof0 = 0; eof0 = 0; d0 = 0;
        init1 = 0; mode1 = 0; v1 = 0; sof1 = 0; eof1 = 0; d1 = 0;
        idle(3);
        check_reset(0);
        check_reset(1);
        RST = 1'b1;
        idle(2);

        // CRC-8 generate over "123456789"
        rl_cnt[0] = 0;
        run_frame(0, 1'b0, msg, 1);
        idle(5);
        check("t1_crc", last_crc[0], 32'hBC);
        check("t1_ready_low", rl_cnt[0], 1);

        // single-word frame
        q = '{8'h01};
        run_frame(0, 1'b0, q, 1);
        idle(4);
        check("t2_crc", last_crc[0], 32'hD5);

        // check mode, good then bad trailer, back to back
        q = msg; q.push_back(8'hBC);
        run_frame(0, 1'b1, q, 1);
        q = msg; q.push_back(8'hBD);
        run_frame(0, 1'b1, q, 1);
        idle(1);
        check("t3_bad_ok", {31'h0, last_ok[0]}, 32'h0);
        q = msg; q.push_back(8'hBC);
        run_frame(0, 1'b1, q, 1);
        idle(3);
        check("t3_good_ok", {31'h0, last_ok[0]}, 32'h1);
        check("t3_good_crc", last_crc[0], 32'h0);

        // CRC-32/MPEG-2 generate
        rl_cnt[1] = 0;
        run_frame(1, 1'b0, msg, 4);
        idle(8);
        check("t4_crc", last_crc[1], 32'h0376E6E7);
        check("t4_ready_low", rl_cnt[1], 4);

        // word without SOF, then SOF mid-frame
        send(0, 1'b0, 1'b0, 8'h55, 1'b0);
        err_exp[0]++;
        idle(3);
        check("t5_err_sof", err_seen[0], err_exp[0]);
        cvb = cv_cnt[0];
        q = '{8'hA0, 8'hA1, 8'hA2};
        run_partial(0, q);
        run_frame(0, 1'b0, msg, 1);
        idle(4);
        check("t5_cv_count", cv_cnt[0] - cvb, 1);
        check("t5_crc", last_crc[0], 32'hBC);

        // reset during APPEND after two of four CRC words
        run_frame(1, 1'b0, msg, 2);
        @(posedge CLK);
        @(posedge CLK);
        #1 RST = 1'b0;
        @(posedge CLK);
        #1 RST = 1'b1;
        check_reset(1);
        check("t6_pending", eo1.size(), 0);
        idle(2);
        run_frame(1, 1'b0, msg, 4);
        idle(8);
        check("t6_next_crc", last_crc[1], 32'h0376E6E7);

        // INIT mid-frame
        q = '{8'h11, 8'h22};
        run_partial(0, q);
        init0 = 1'b1;
        @(posedge CLK);
        #1 init0 = 1'b0;
        check_reset(0);
        q = '{8'h01};
        run_frame(0, 1'b0, q, 1);
        idle(3);
        check("init_next_crc", last_crc[0], 32'hD5);

        // randomized frames against the reference model
        for (int n = 0; n < 30; n++) begin
            id  = $urandom_range(0, 1);
            md  = 1'($urandom_range(0, 1));
            len = $urandom_range(1, 8);
            q = {};
            for (int k = 0; k < len; k++) q.push_back(8'($urandom));
            if (md) begin
                raw = ref_raw(id, q);
                if (id == 0) q.push_back(raw[7:0]);
                else for (int j = 3; j >= 0; j--) q.push_back(raw[8*j +: 8]);
                if ($urandom_range(0, 2) == 0) begin
                    int p;
                    p = $urandom_range(0, q.size() - 1);
                    q[p] = q[p] ^ 8'(1 << $urandom_range(0, 7));
                end
            end
            run_frame(id, md, q, 4);
            idle($urandom_range(0, 2));
        end

        idle(10);
        check("end_q_out0", eo0.size(), 0);
        check("end_q_out1", eo1.size(), 0);
        check("end_q_crc0", ec0.size(), 0);
        check("end_q_crc1", ec1.size(), 0);
        check("end_err1", err_seen[1], err_exp[1]);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
